writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of all result and write paths.
REQ-002 Parameter NREG_BITS, default 5, register-index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low: asserted when 0.
REQ-005 run  input  1  global advance enable; 0 freezes all state.
REQ-006 alu_valid  input  1  ALU result present this cycle.
REQ-007 alu_rd  input  NREG_BITS  ALU destination register.
REQ-008 alu_data  input  XLEN  ALU result.
REQ-009 alu_ready  output  1  skid buffer can accept an ALU result.
REQ-010 ld_req_valid  input  1  load issued to memory this cycle.
REQ-011 ld_req_rd / ld_req_funct3 / ld_req_off  input  NREG_BITS / 3 / 2  load destination, size+sign code, byte offset.
REQ-012 ld_req_ready  output  1  no load outstanding.
REQ-013 mem_rvalid / mem_rdata  input  1 / XLEN  memory load response.
REQ-014 waddr / wdata / reg_we  output  NREG_BITS / XLEN / 1  register-file write port.
REQ-015 busy_valid / busy_rd  output  1 / NREG_BITS  outstanding load destination, for hazard stall.

Function
REQ-016 States: IDLE, WAIT_LOAD; ld_req_ready = (state == IDLE), registered.
REQ-017 IDLE + run + ld_req_valid: capture rd/funct3/off, go WAIT_LOAD; busy_valid=1, busy_rd=captured rd from next cycle.
REQ-018 WAIT_LOAD + run + mem_rvalid: write extended load result, return to IDLE, busy_valid=0 next cycle.
REQ-019 ld_req_valid while WAIT_LOAD: ignored, no capture; mem_rvalid in IDLE: ignored.
REQ-020 Load extension: 000 LB sign, 100 LBU zero, byte at off; 001 LH sign, 101 LHU zero, halfword at off[1] (off[0] ignored); 010 LW and 011/110/111 pass raw word.
REQ-021 Write latency: event accepted in cycle N -> waddr/wdata/reg_we valid in cycle N+1, registered outputs, reg_we high exactly one cycle per write.
REQ-022 One write per cycle; load response has priority over ALU result.
REQ-023 ALU result colliding with load response is held in a one-entry skid buffer and written the following cycle; alu_ready=0 while buffer full.
REQ-024 Skid buffer content written before any new ALU result; alu_valid while alu_ready=0 is dropped (upstream contract violation).
REQ-025 Destination 0: event consumed, reg_we stays 0; load to x0 still occupies WAIT_LOAD until response.
REQ-026 run=0: no state, buffer or capture change; reg_we driven 0; waddr/wdata hold.

Reset
REQ-027 On reset: state IDLE, skid buffer empty, reg_we=0, waddr=0, wdata=0, busy_valid=0, busy_rd=0, alu_ready=1, ld_req_ready=1.
REQ-028 Reset mid-load abandons the load; a later mem_rvalid in IDLE produces no write.
REQ-029 Reset has priority over run and every input.

Structure
REQ-030 Shared package mspu_pkg holds the load funct3 constants and the wb_state_t enum.
REQ-031 One sub-module load_extend: combinational funct3/offset/data to XLEN result.

Verification
REQ-032 alu_valid, rd=5, data=0x1234 in cycle N -> reg_we=1, waddr=5, wdata=0x1234 in N+1 only.
REQ-033 Load LB off=3 rd=7, response 0x80FF_0000 -> wdata=0xFFFF_FF80; LHU off=2 same data -> 0x0000_80FF.
REQ-034 Load response and ALU result (rd=3, 0xA) same cycle -> load written N+1, rd=3 0xA written N+2, alu_ready=0 for one cycle.
REQ-035 Load to x0 and ALU to x0 -> reg_we never asserted; busy_valid high until response.
REQ-036 Reset asserted while WAIT_LOAD, then mem_rvalid -> no write, ld_req_ready=1, busy_valid=0.
REQ-037 run=0 during WAIT_LOAD with mem_rvalid pulse -> no write, state stays WAIT_LOAD.

Source files
------------

// File: rtl/mspu_pkg.sv
// Shared definitions for the memory/scalar pipeline: load size/sign codes
// and the writeback FSM state type.
package mspu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a load response and sign- or
// zero-extends it to XLEN; word and unknown codes pass the raw data.
module load_extend
  import mspu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (off)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    // Halfword loads are aligned by off[1]; off[0] does not matter here.
    half_sel = off[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: merges ALU results and load responses into one
// write port, tracks a single outstanding load, and skids a colliding ALU result.
module writeback_unit
  import mspu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 alu_valid,
  input  logic [NREG_BITS-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 ld_req_valid,
  input  logic [NREG_BITS-1:0] ld_req_rd,
  input  logic [2:0]           ld_req_funct3,
  input  logic [1:0]           ld_req_off,
  output logic                 ld_req_ready,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [NREG_BITS-1:0] waddr,
  output logic [XLEN-1:0]      wdata,
  output logic                 reg_we,
  output logic                 busy_valid,
  output logic [NREG_BITS-1:0] busy_rd,
  output wb_state_t            state
);

  // Handshake: an ALU result is taken when alu_valid && alu_ready on a run
  // cycle; a load is issued when ld_req_valid && ld_req_ready on a run cycle.
  logic [NREG_BITS-1:0] cap_rd;
  logic [2:0]           cap_funct3;
  logic [1:0]           cap_off;
  logic                 skid_valid;
  logic [NREG_BITS-1:0] skid_rd;
  logic [XLEN-1:0]      skid_data;
  logic [XLEN-1:0]      ld_result;
  logic                 load_fire;
  logic                 alu_take;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (cap_funct3),
    .off    (cap_off),
    .data   (mem_rdata),
    .result (ld_result)
  );

  assign load_fire    = (state == WB_WAIT_LOAD) && mem_rvalid;
  assign alu_take     = alu_valid && !skid_valid;
  assign alu_ready    = !skid_valid;
  assign ld_req_ready = (state == WB_IDLE);
  assign busy_valid   = (state == WB_WAIT_LOAD);
  assign busy_rd      = cap_rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WB_IDLE;
      cap_rd     <= '0;
      cap_funct3 <= '0;
      cap_off    <= '0;
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
      waddr      <= '0;
      wdata      <= '0;
      reg_we     <= 1'b0;
    end else if (!run) begin
      reg_we <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (ld_req_valid) begin
            cap_rd     <= ld_req_rd;
            cap_funct3 <= ld_req_funct3;
            cap_off    <= ld_req_off;
            state      <= WB_WAIT_LOAD;
          end
        end
        WB_WAIT_LOAD: begin
          if (mem_rvalid) state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase

      // Load wins the port; a same-cycle ALU result waits one cycle in the skid.
      if (load_fire) begin
        if (cap_rd != '0) begin
          reg_we <= 1'b1;
          waddr  <= cap_rd;
          wdata  <= ld_result;
        end
        if (alu_take) begin
          skid_valid <= 1'b1;
          skid_rd    <= alu_rd;
          skid_data  <= alu_data;
        end
      end else if (skid_valid) begin
        skid_valid <= 1'b0;
        if (skid_rd != '0) begin
          reg_we <= 1'b1;
          waddr  <= skid_rd;
          wdata  <= skid_data;
        end
      end else if (alu_valid && (alu_rd != '0)) begin
        reg_we <= 1'b1;
        waddr  <= alu_rd;
        wdata  <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, all
// compared each cycle against a transaction-level reference model.
module tb_writeback_unit;
  import mspu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_req_valid = 1'b0;
  logic [4:0]  ld_req_rd = '0;
  logic [2:0]  ld_req_funct3 = '0;
  logic [1:0]  ld_req_off = '0;
  logic        ld_req_ready;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_we;
  logic        busy_valid;
  logic [4:0]  busy_rd;
  wb_state_t   state;

  int chk_count = 0;
  int err_count = 0;

  // Reference model state
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [4:0]  skid_rd_q[$];
  logic [31:0] exp_q[$];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  writeback_unit #(.XLEN(32), .NREG_BITS(5)) dut (
    .clk(clk), .reset(reset), .run(run),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_req_valid(ld_req_valid), .ld_req_rd(ld_req_rd), .ld_req_funct3(ld_req_funct3),
    .ld_req_off(ld_req_off), .ld_req_ready(ld_req_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .waddr(waddr), .wdata(wdata), .reg_we(reg_we),
    .busy_valid(busy_valid), .busy_rd(busy_rd), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] data);
    int v;
    case (f3)
      3'b000, 3'b100: begin
        v = int'((data >> (8 * off)) & 32'hFF);
        if (f3 == 3'b000 && v > 127) v = v - 256;
        return 32'(v);
      end
      3'b001, 3'b101: begin
        v = int'((data >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 3'b001 && v > 32767) v = v - 65536;
        return 32'(v);
      end
      default: return data;
    endcase
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit was_busy;
    bit alu_ok;
    if (!reset) begin
      m_busy = 0; m_rd = '0; m_f3 = '0; m_off = '0;
      skid_rd_q.delete(); exp_q.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0;
      return;
    end
    m_we = 0;
    if (!run) return;
    was_busy = m_busy;
    alu_ok = (skid_rd_q.size() == 0);
    if (was_busy && mem_rvalid) begin
      if (m_rd != 0) begin
        m_we = 1; m_waddr = m_rd; m_wdata = m_ext(m_f3, m_off, mem_rdata);
      end
      m_busy = 0;
      if (alu_valid && alu_ok) begin
        skid_rd_q.push_back(alu_rd);
        exp_q.push_back(alu_data);
      end
    end else if (skid_rd_q.size() != 0) begin
      logic [4:0]  r;
      logic [31:0] d;
      r = skid_rd_q.pop_front();
      d = exp_q.pop_front();
      if (r != 0) begin
        m_we = 1; m_waddr = r; m_wdata = d;
      end
    end else if (alu_valid && alu_rd != 0) begin
      m_we = 1; m_waddr = alu_rd; m_wdata = alu_data;
    end
    if (!was_busy && ld_req_valid) begin
      m_busy = 1; m_rd = ld_req_rd; m_f3 = ld_req_funct3; m_off = ld_req_off;
    end
  endtask

  task automatic step(input bit rst_n, input bit rn,
                      input bit av, input logic [4:0] ard, input logic [31:0] adata,
                      input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                      input logic [1:0] loff, input bit mv, input logic [31:0] mdata);
    reset = rst_n; run = rn;
    alu_valid = av; alu_rd = ard; alu_data = adata;
    ld_req_valid = lv; ld_req_rd = lrd; ld_req_funct3 = lf3; ld_req_off = loff;
    mem_rvalid = mv; mem_rdata = mdata;
    @(posedge clk);
    model_step();
    #1;
    check("reg_we", 32'(reg_we), 32'(m_we));
    check("waddr", 32'(waddr), 32'(m_waddr));
    check("wdata", wdata, m_wdata);
    check("alu_ready", 32'(alu_ready), 32'(skid_rd_q.size() == 0));
    check("ld_req_ready", 32'(ld_req_ready), 32'(!m_busy));
    check("busy_valid", 32'(busy_valid), 32'(m_busy));
    check("busy_rd", 32'(busy_rd), 32'(m_rd));
  endtask

  task automatic idle();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, 1, 1, 5'd4, 32'h55, 1, 5'd6, 3'b010, 0, 1, 32'h77);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_wdata", wdata, 32'd0);

    // Single ALU write, one cycle only
    step(1, 1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
    check("alu_we", 32'(reg_we), 32'd1);
    check("alu_waddr", 32'(waddr), 32'd5);
    check("alu_wdata", wdata, 32'h1234);
    idle();
    check("alu_we_drop", 32'(reg_we), 32'd0);

    // LB off 3 and LHU off 2 of the same word
    step(1, 1, 0, 0, 0, 1, 5'd7, 3'b000, 2'd3, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
    check("lb_wdata", wdata, 32'hFFFF_FF80);
    step(1, 1, 0, 0, 0, 1, 5'd7, 3'b101, 2'd2, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
    check("lhu_wdata", wdata, 32'h0000_80FF);

    // Load response collides with ALU result
    step(1, 1, 0, 0, 0, 1, 5'd9, 3'b010, 0, 0, 0);
    step(1, 1, 1, 5'd3, 32'hA, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("col_ld_waddr", 32'(waddr), 32'd9);
    check("col_alu_ready", 32'(alu_ready), 32'd0);
    idle();
    check("col_skid_waddr", 32'(waddr), 32'd3);
    check("col_skid_wdata", wdata, 32'hA);
    check("col_alu_ready2", 32'(alu_ready), 32'd1);
    idle();

    // Destination x0 for load and ALU
    step(1, 1, 0, 0, 0, 1, 5'd0, 3'b010, 0, 0, 0);
    step(1, 1, 1, 5'd0, 32'h99, 0, 0, 0, 0, 0, 0);
    check("x0_busy", 32'(busy_valid), 32'd1);
    check("x0_alu_we", 32'(reg_we), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    check("x0_ld_we", 32'(reg_we), 32'd0);

    // Reset mid-load abandons it
    step(1, 1, 0, 0, 0, 1, 5'd12, 3'b010, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111);
    check("rstld_we", 32'(reg_we), 32'd0);
    check("rstld_ready", 32'(ld_req_ready), 32'd1);

    // run=0 freezes WAIT_LOAD against a response pulse
    step(1, 1, 0, 0, 0, 1, 5'd13, 3'b010, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2222);
    check("frz_we", 32'(reg_we), 32'd0);
    check("frz_busy", 32'(busy_valid), 32'd1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3333);
    check("frz_wdata", wdata, 32'h3333);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ard, lrd;
      ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 1) == 1), ard, $urandom,
           ($urandom_range(0, 2) == 0), lrd, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 4) < 2), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
    $finish;
  end

endmodule
